// File: rtl/rgb_ctrl_pkg.sv
// rgb_ctrl_pkg: shared types and constants for the RGB comparator sequencer.
//   state_t   - sequencer states (IDLE, SETTLE, SHOW)
//   rgb_t     - captured comparator result {r, g, b}
//   SCAN_LAST - index of the last operand pair in a self-test scan
//   cnt_width - counter width for an N-cycle phase ($clog2, minimum 1)
package rgb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SHOW   = 2'd2
  } state_t;

  typedef struct packed {
    logic r;  // a >= b
    logic g;  // b >= a
    logic b;  // a != b
  } rgb_t;

  localparam logic [3:0] SCAN_LAST = 4'd15;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rgb_pwm.sv
// rgb_pwm: free-running PWM counter and brightness compare.
//   clk, rst    - system clock, synchronous active-high reset
//   brightness  - duty setting; 0 = always off, max = (2^PWM_BITS-1)/2^PWM_BITS
//   en          - enable for the NEXT cycle: high when the counter value that
//                 will be present after the coming edge is below brightness.
//                 The parent registers its LED outputs from this, so the
//                 registered LED lines up with the counter value of its cycle.
module rgb_pwm #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                en
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] cnt_next;

  // Natural wrap from all-ones back to zero.
  assign cnt_next = cnt + PWM_BITS'(1);
  assign en       = (cnt_next < brightness);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/rgb_cmp_ctrl.sv
// rgb_cmp_ctrl: sequencer for the 2-bit RGB comparator datapath.
// Accepts operand pairs, drives them to the comparator, waits for it to
// settle, captures {r,g,b} and shows it on PWM-dimmed LEDs for a hold time.
// scan_start runs all 16 pairs (a outer loop, b inner loop) as a self-test.
//
// Ports:
//   clk, rst           - system clock, synchronous active-high reset
//   in_valid/in_ready  - operand handshake; in_a/in_b are the operands
//   scan_start         - one-cycle pulse starting a 16-pair scan
//   brightness         - LED duty, sampled live
//   cmp_a, cmp_b       - registered operands to the comparator
//   cmp_r/cmp_g/cmp_bl - comparator results
//   res                - last captured {r,g,b}, held until the next capture
//   led_r/led_g/led_b  - PWM-gated result bits, only during SHOW
//   busy               - high whenever the sequencer is not IDLE
//   done               - one-cycle pulse after a single op or a full scan
//
// Handshake: a pair transfers on a clock edge where in_valid and in_ready are
// both high. in_ready is combinational, high only in IDLE while scan_start is
// low, so a simultaneous scan_start wins and the pair is not taken. in_valid
// carries no obligation to stay asserted and is ignored while busy.
module rgb_cmp_ctrl
  import rgb_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1000,
  parameter int PWM_BITS      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [1:0]          in_a,
  input  logic [1:0]          in_b,
  output logic                in_ready,
  input  logic                scan_start,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [1:0]          cmp_a,
  output logic [1:0]          cmp_b,
  input  logic                cmp_r,
  input  logic                cmp_g,
  input  logic                cmp_bl,
  output logic [2:0]          res,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic                busy,
  output logic                done
);

  localparam int SW = cnt_width(SETTLE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

  state_t      state;
  logic [SW-1:0] settle_cnt;
  logic [HW-1:0] hold_cnt;
  logic [3:0]  scan_idx;
  logic [3:0]  scan_idx_next;
  logic        scan_on;
  rgb_t        res_q;
  rgb_t        cmp_res;
  logic [2:0]  led_q;
  logic        pwm_en;

  rgb_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk       (clk),
    .rst       (rst),
    .brightness(brightness),
    .en        (pwm_en)
  );

  assign in_ready      = (state == IDLE) & ~scan_start;
  assign scan_idx_next = scan_idx + 4'd1;
  assign cmp_res       = '{r: cmp_r, g: cmp_g, b: cmp_bl};

  assign res   = res_q;
  assign led_r = led_q[2];
  assign led_g = led_q[1];
  assign led_b = led_q[0];

  // LEDs are registered from the state being entered, so they are lit for
  // exactly the SHOW cycles and dark in the first IDLE/SETTLE cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      hold_cnt   <= '0;
      scan_idx   <= '0;
      scan_on    <= 1'b0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      res_q      <= '0;
      led_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done  <= 1'b0;
      led_q <= '0;
      case (state)
        IDLE: begin
          if (scan_start) begin
            state      <= SETTLE;
            busy       <= 1'b1;
            scan_on    <= 1'b1;
            scan_idx   <= '0;
            cmp_a      <= 2'd0;
            cmp_b      <= 2'd0;
            settle_cnt <= '0;
          end else if (in_valid) begin
            state      <= SETTLE;
            busy       <= 1'b1;
            cmp_a      <= in_a;
            cmp_b      <= in_b;
            settle_cnt <= '0;
          end
        end

        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            res_q    <= cmp_res;
            led_q    <= cmp_res & {3{pwm_en}};
            hold_cnt <= '0;
            state    <= SHOW;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        SHOW: begin
          if (hold_cnt == HOLD_LAST) begin
            if (scan_on && (scan_idx != SCAN_LAST)) begin
              // a is the outer loop: index bits [3:2] are a, [1:0] are b.
              scan_idx   <= scan_idx_next;
              cmp_a      <= scan_idx_next[3:2];
              cmp_b      <= scan_idx_next[1:0];
              settle_cnt <= '0;
              state      <= SETTLE;
            end else begin
              scan_on <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
            led_q    <= res_q & {3{pwm_en}};
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_cmp_ctrl.sv
// tb_rgb_cmp_ctrl: self-checking bench for rgb_cmp_ctrl with an attached
// behavioural comparator. Drivers push expected captures and done times into
// queues; a monitor checks res, LEDs, busy and done every cycle.
module tb_rgb_cmp_ctrl;

  localparam int S  = 2;
  localparam int H  = 8;
  localparam int PW = 2;
  localparam int PERIOD = 1 << PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [1:0]    in_a = '0;
  logic [1:0]    in_b = '0;
  logic          in_ready;
  logic          scan_start = 1'b0;
  logic [PW-1:0] brightness = '0;
  logic [1:0]    cmp_a, cmp_b;
  logic          cmp_r, cmp_g, cmp_bl;
  logic [2:0]    res;
  logic          led_r, led_g, led_b;
  logic          busy, done;

  rgb_cmp_ctrl #(
    .SETTLE_CYCLES(S),
    .HOLD_CYCLES  (H),
    .PWM_BITS     (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .scan_start(scan_start),
    .brightness(brightness),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_r     (cmp_r),
    .cmp_g     (cmp_g),
    .cmp_bl    (cmp_bl),
    .res       (res),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b),
    .busy      (busy),
    .done      (done)
  );

  // Comparator datapath model.
  assign cmp_r  = (cmp_a >= cmp_b);
  assign cmp_g  = (cmp_b >= cmp_a);
  assign cmp_bl = (cmp_a != cmp_b);

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int         cyc;
    logic [2:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_rst = 0;
  int busy_from = 1;
  int busy_to   = 0;
  int show_from = 1;
  int show_to   = 0;
  logic [2:0] res_model = '0;
  logic       chk_en = 1'b0;
  int led_r_ones = 0, led_g_ones = 0, led_b_ones = 0;

  function automatic logic [2:0] ref_cmp(input int a, input int b);
    return {a >= b, b >= a, a != b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [PW-1:0] last_bright;
    logic          skip_led;
    logic [2:0]    exp_led;
    logic          exp_done;
    int            pcnt;
    last_bright = '0;
    skip_led    = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      pcnt = (cyc - last_rst) % PERIOD;
      // After a brightness change, the new duty is only required from the
      // start of the next PWM period.
      if (brightness !== last_bright) begin
        skip_led    = 1'b1;
        last_bright = brightness;
      end else if (pcnt == 0) begin
        skip_led = 1'b0;
      end
      if (!chk_en) continue;

      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        chk("capture", res, exp_q[0].res);
        res_model = exp_q[0].res;
        show_from = cyc;
        show_to   = cyc + H - 1;
        void'(exp_q.pop_front());
      end else begin
        chk("res_hold", res, res_model);
      end

      if (cyc >= show_from && cyc <= show_to)
        exp_led = res_model & {3{pcnt < int'(brightness)}};
      else
        exp_led = 3'b000;
      if (!skip_led || exp_led == 3'b000 && !(cyc >= show_from && cyc <= show_to))
        chk("leds", {led_r, led_g, led_b}, exp_led);
      if (led_r === 1'b1) led_r_ones++;
      if (led_g === 1'b1) led_g_ones++;
      if (led_b === 1'b1) led_b_ones++;

      chk("busy", busy, (cyc >= busy_from && cyc <= busy_to));

      exp_done = 1'b0;
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        exp_done = 1'b1;
        void'(done_q.pop_front());
      end
      chk("done", done, exp_done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_ones();
    led_r_ones = 0;
    led_g_ones = 0;
    led_b_ones = 0;
  endtask

  task automatic single_op(input logic [1:0] a, input logic [1:0] b,
                           input bit hold_v, input bit bchange);
    int t;
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    t = cyc + 1;
    e.cyc = t + S;
    e.res = ref_cmp(int'(a), int'(b));
    exp_q.push_back(e);
    done_q.push_back(t + S + H);
    busy_from = t;
    busy_to   = t + S + H - 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 2'($urandom);
    in_b = 2'($urandom);
    chk("cmp_a", cmp_a, a);
    chk("cmp_b", cmp_b, b);
    while (cyc < t + S + H) begin
      @(negedge clk);
      if (hold_v && cyc == t + S) begin
        in_valid = 1'b1;
        chk("in_ready_show", in_ready, 1'b0);
      end
      if (hold_v && cyc == t + S + H - 1) in_valid = 1'b0;
      if (bchange && cyc == t + S + 2) brightness = PW'(2);
    end
  endtask

  // Runs a scan; abort_idx >= 0 resets mid-SHOW of that scan index.
  task automatic scan(input bit with_valid, input int abort_idx);
    int t;
    exp_t e;
    @(negedge clk);
    scan_start = 1'b1;
    if (with_valid) begin
      in_valid = 1'b1;
      in_a = 2'($urandom);
      in_b = 2'($urandom);
    end
    #1;
    chk("in_ready_scan", in_ready, 1'b0);
    t = cyc + 1;
    for (int i = 0; i < 16; i++) begin
      e.cyc = t + i * (S + H) + S;
      e.res = ref_cmp(i / 4, i % 4);
      exp_q.push_back(e);
    end
    done_q.push_back(t + 16 * (S + H));
    busy_from = t;
    busy_to   = t + 16 * (S + H) - 1;
    @(negedge clk);
    scan_start = 1'b0;
    in_valid   = 1'b0;
    if (abort_idx >= 0) begin
      while (cyc < t + abort_idx * (S + H) + S + 3) @(negedge clk);
      rst = 1'b1;
      last_rst = cyc + 1;
      exp_q.delete();
      done_q.delete();
      busy_to   = 0;
      busy_from = 1;
      show_to   = 0;
      show_from = 1;
      res_model = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_leds", {led_r, led_g, led_b}, 3'b000);
      chk("abort_res", res, 3'b000);
      chk("abort_done", done, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
    end else begin
      while (cyc < t + 16 * (S + H)) @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    repeat (3) @(negedge clk);
    last_rst = cyc;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_res", res, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_leds", {led_r, led_g, led_b}, 3'b000);
    chk("rst_cmp", {cmp_a, cmp_b}, 4'h0);
    chk_en = 1'b1;

    brightness = PW'(3);
    repeat (PERIOD + 1) @(negedge clk);
    clear_ones();
    single_op(2'd2, 2'd1, 1'b0, 1'b0);
    chk("duty_r_3of4", led_r_ones, 6);
    chk("duty_g_off", led_g_ones, 0);
    chk("duty_b_3of4", led_b_ones, 6);

    clear_ones();
    single_op(2'd1, 2'd1, 1'b0, 1'b0);
    chk("eq_led_b", led_b_ones, 0);
    chk("eq_led_g", led_g_ones, 6);

    scan(1'b0, -1);
    scan(1'b1, -1);
    single_op(2'd0, 2'd2, 1'b1, 1'b0);

    brightness = '0;
    repeat (PERIOD + 1) @(negedge clk);
    clear_ones();
    single_op(2'd3, 2'd0, 1'b0, 1'b0);
    chk("dark_leds", led_r_ones + led_g_ones + led_b_ones, 0);
    single_op(2'd3, 2'd1, 1'b0, 1'b1);

    scan(1'b0, 5);
    brightness = PW'(3);
    single_op(2'd0, 2'd3, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      brightness = PW'($urandom_range(0, PERIOD - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0)
        scan(1'($urandom_range(0, 1)), -1);
      else
        single_op(2'($urandom), 2'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rgb_cmp_ctrl.md
Name: rgb_cmp_ctrl

Overview:
Sequencer for the 2-bit RGB comparator datapath (r = a>=b, g = b>=a, b = a!=b). It accepts operand pairs through a valid/ready handshake and drives them onto the comparator. It waits for the comparator to settle, captures the result, and shows it on the RGB LEDs for a programmable hold time with PWM brightness. A scan mode steps through all 16 operand combinations automatically, for board-level self-test.

Parameters:
SETTLE_CYCLES, 2, cycles between driving comparator inputs and capturing its outputs (>=1)
HOLD_CYCLES, 1000, cycles each captured result is shown on the LEDs (>=1)
PWM_BITS, 4, width of the PWM counter and of the brightness input

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_a  input  2  operand A
in_b  input  2  operand B
in_ready  output  1  block can accept an operand pair
scan_start  input  1  single-cycle pulse; starts a 16-pair scan
brightness  input  PWM_BITS  LED duty setting, sampled live
cmp_a  output  2  registered operand A to the comparator
cmp_b  output  2  registered operand B to the comparator
cmp_r  input  1  comparator R result (a>=b)
cmp_g  input  1  comparator G result (b>=a)
cmp_bl  input  1  comparator B result (a!=b)
res  output  3  last captured {r,g,b}; held until the next capture
led_r  output  1  PWM-gated R
led_g  output  1  PWM-gated G
led_b  output  1  PWM-gated B
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a single operation or a full scan completes

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; cmp_a=cmp_b=0; res=0; leds=0; busy=0; done=0; counters=0; scan index=0.
- Reset mid-operation aborts immediately. There is no done pulse, the LEDs go off the next cycle, and any scan in progress is abandoned.
- in_ready = (state==IDLE) & ~scan_start. It is combinational and therefore 1 out of reset.
- States and transitions:
  - IDLE -> SETTLE on scan_start. This loads scan index 0 (a=0, b=0) and sets the scan flag.
  - IDLE -> SETTLE on in_valid & in_ready. This loads cmp_a=in_a and cmp_b=in_b.
  - SETTLE lasts exactly SETTLE_CYCLES cycles. At its final edge, res<={cmp_r,cmp_g,cmp_bl}, then -> SHOW.
  - SHOW lasts exactly HOLD_CYCLES cycles, then:
    - If not scanning: -> IDLE with done=1 for the first IDLE cycle.
    - If scanning and index<15: increment the index, drive the next pair, -> SETTLE.
    - If scanning and index==15: -> IDLE, done=1, clear the scan flag.
- Scan order: a is the outer loop, b the inner loop. Index i gives a=i[3:2], b=i[1:0], running 00/00, 00/01 ... 11/11.
- Latency for a single operation: handshake edge T. cmp_* is valid from T+1. Capture happens at edge T+SETTLE_CYCLES. LEDs are active for HOLD_CYCLES cycles. done is high in cycle T+1+SETTLE_CYCLES+HOLD_CYCLES.
- scan_start and in_valid in the same IDLE cycle: scan wins and the pair is not accepted, because in_ready=0.
- in_valid and scan_start are ignored while busy.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0.
  - led_x = (state==SHOW) & res_x & (pwm_cnt < brightness), registered.
  - brightness=0 means always off. The maximum value gives a duty of (2^PWM_BITS-1)/2^PWM_BITS.
- The LEDs are 0 in IDLE and SETTLE. res holds its value in all states.
- Counter widths are $clog2 of the respective parameter (minimum 1). The counters reload on every state entry.

Decomposition:
- Package rgb_ctrl_pkg holds:
  - the state enum typedef (IDLE, SETTLE, SHOW)
  - the rgb_t packed struct {r,g,b}
  - the localparam SCAN_LAST=15
- One sub-module, rgb_pwm: it contains the free-running counter and the compare, and produces a single enable used to gate all three LEDs.

Test Plan:
- Reset, then single op a=2 b=1 (SETTLE=2, HOLD=8, PWM_BITS=2, brightness=3). Required: in_ready=1 before the op, res=3'b101 at capture, LEDs r and b toggle 3-of-4 duty over 8 cycles, done pulses at cycle T+11.
- Single op a=1 b=1. Required: res=3'b110, led_b stays 0 throughout SHOW.
- scan_start with the comparator model attached. Required: 16 captures in a-outer/b-inner order, each res matching the a>=b, b>=a, a!=b equations. busy stays high throughout, and exactly one done pulse follows pair 11/11.
- scan_start and in_valid in the same cycle. Required: in_ready=0, the scan runs, and the pair is dropped. in_valid asserted during SHOW is not accepted.
- brightness=0 during SHOW. Required: all LEDs 0 while res is still updated. Changing brightness mid-SHOW to 2 gives 2-of-4 duty from the next counter period.
- rst asserted mid-SHOW of scan index 5. Required: the next cycle is IDLE with LEDs 0, busy 0, no done, and res=0. A new single op then completes normally.
